// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and types for the convolution input loader.
//   INWIDTH_D, DI_W_D, DI_H_D, FIL_S_D : default word width / ifmap size / filter side
//   DO_W_D, DO_H_D                     : resulting valid-convolution output size
//   ld_state_e                         : loader FSM state encoding
//   cnt_w()                            : counter/index width for a dimension of n elements
package conv_pkg;

  localparam int INWIDTH_D = 16;
  localparam int DI_W_D    = 7;
  localparam int DI_H_D    = 7;
  localparam int FIL_S_D   = 3;
  localparam int DO_W_D    = DI_W_D - FIL_S_D + 1;
  localparam int DO_H_D    = DI_H_D - FIL_S_D + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_FIL = 2'd1,
    LOAD_DAT = 2'd2,
    HOLD     = 2'd3
  } ld_state_e;

  // Width needed to index n elements (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_ld_cnt.sv
// conv_ld_cnt: row-major row/column position counter for the loader.
//   clk, rst     : clock, asynchronous active-low reset
//   clr_i        : synchronous clear to (0,0); wins over en_i
//   en_i         : advance one position
//   last_col_i   : highest column index of the current matrix
//   last_row_i   : highest row index of the current matrix
//   col_o, row_o : current position
//   wrap_o       : en_i while sitting on the final position (counter returns to 0,0)
module conv_ld_cnt
  import conv_pkg::*;
#(
  parameter int MAX_W = DI_W_D,
  parameter int MAX_H = DI_H_D,
  parameter int CW    = cnt_w(MAX_W),
  parameter int RW    = cnt_w(MAX_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] last_col_i,
  input  logic [RW-1:0] last_row_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          wrap_o
);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == last_col_i);
  assign row_end = (row_q == last_row_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign wrap_o = en_i && col_end && row_end;

endmodule

// File: rtl/conv_in_loader.sv
// conv_in_loader: streams a tile frame (filter words, then ifmap words, both
// row-major) from a valid/ready source into FILTER / DATA_IN and presents the
// complete tile to the PE array with out_valid until out_ready.
//   clk, rst          : clock, asynchronous active-low reset
//   keep_filter       : (only with CONV_FILTER_REUSE_EN) at the tile handshake,
//                       next frame carries ifmap words only and FILTER is kept
//   in_valid/in_ready : word handshake; in_data signed word, in_last on final word
//   out_valid/out_ready : tile handshake
//   FILTER, DATA_IN   : presented tile, only ever updated with a complete frame
//   frame_err         : one-cycle pulse when in_last is misplaced or missing
// Optional feature macro: CONV_FILTER_REUSE_EN.
// Words land in staging buffers and are copied to the output arrays in the
// cycle the final word is accepted, so an aborted or reset frame never
// disturbs the presented tile.
module conv_in_loader
  import conv_pkg::*;
#(
  parameter int INWIDTH = INWIDTH_D,
  parameter int DI_W    = DI_W_D,
  parameter int DI_H    = DI_H_D,
  parameter int FIL_S   = FIL_S_D
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef CONV_FILTER_REUSE_EN
  input  logic                      keep_filter,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [INWIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [INWIDTH-1:0] FILTER  [0:FIL_S-1][0:FIL_S-1],
  output logic signed [INWIDTH-1:0] DATA_IN [0:DI_H-1][0:DI_W-1],
  output logic                      frame_err
);

  localparam int CMAX_W = (FIL_S > DI_W) ? FIL_S : DI_W;
  localparam int CMAX_H = (FIL_S > DI_H) ? FIL_S : DI_H;
  localparam int CW     = cnt_w(CMAX_W);
  localparam int RW     = cnt_w(CMAX_H);
  localparam int FCW    = cnt_w(FIL_S);
  localparam int DCW    = cnt_w(DI_W);
  localparam int DRW    = cnt_w(DI_H);

  ld_state_e state_q, state_d;

  logic          xfer;
  logic          cnt_clr;
  logic          cnt_wrap;
  logic          commit;
  logic          err_d;
  logic          keep_fil;
  logic          out_valid_q;
  logic          frame_err_q;
  logic [CW-1:0] col, last_col;
  logic [RW-1:0] row, last_row;

  logic signed [INWIDTH-1:0] fil_stg [0:FIL_S-1][0:FIL_S-1];
  logic signed [INWIDTH-1:0] dat_stg [0:DI_H-1][0:DI_W-1];
  logic signed [INWIDTH-1:0] fil_q   [0:FIL_S-1][0:FIL_S-1];
  logic signed [INWIDTH-1:0] dat_q   [0:DI_H-1][0:DI_W-1];

`ifdef CONV_FILTER_REUSE_EN
  assign keep_fil = keep_filter;
`else
  assign keep_fil = 1'b0;
`endif

  assign in_ready = (state_q == LOAD_FIL) || (state_q == LOAD_DAT);
  assign xfer     = in_valid && in_ready;

  // The single counter walks the filter matrix or the ifmap depending on phase.
  assign last_col = (state_q == LOAD_FIL) ? CW'(FIL_S - 1) : CW'(DI_W - 1);
  assign last_row = (state_q == LOAD_FIL) ? RW'(FIL_S - 1) : RW'(DI_H - 1);

  conv_ld_cnt #(
    .MAX_W (CMAX_W),
    .MAX_H (CMAX_H),
    .CW    (CW),
    .RW    (RW)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (xfer),
    .last_col_i (last_col),
    .last_row_i (last_row),
    .col_o      (col),
    .row_o      (row),
    .wrap_o     (cnt_wrap)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD_FIL;
      LOAD_FIL: begin
        if (xfer) begin
          if (in_last) begin
            // in_last is never legal inside the filter part: restart the frame.
            err_d   = 1'b1;
            cnt_clr = 1'b1;
          end else if (cnt_wrap) begin
            cnt_clr = 1'b1;
            state_d = LOAD_DAT;
          end
        end
      end
      LOAD_DAT: begin
        if (xfer) begin
          if (cnt_wrap && in_last) begin
            commit  = 1'b1;
            state_d = HOLD;
          end else if (cnt_wrap || in_last) begin
            err_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = LOAD_FIL;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_clr = 1'b1;
          state_d = keep_fil ? LOAD_DAT : LOAD_FIL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == HOLD);
      frame_err_q <= err_d;
    end
  end

  // Staging buffers: written word by word, contents only matter once committed.
  always_ff @(posedge clk) begin
    if (xfer && (state_q == LOAD_FIL)) begin
      fil_stg[row[FCW-1:0]][col[FCW-1:0]] <= in_data;
    end
    if (xfer && (state_q == LOAD_DAT)) begin
      dat_stg[row[DRW-1:0]][col[DCW-1:0]] <= in_data;
    end
  end

  // Presented tile: the last ifmap word bypasses staging so the tile is
  // complete in the same cycle out_valid rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < FIL_S; r++) begin
        for (int c = 0; c < FIL_S; c++) begin
          fil_q[r][c] <= '0;
        end
      end
      for (int r = 0; r < DI_H; r++) begin
        for (int c = 0; c < DI_W; c++) begin
          dat_q[r][c] <= '0;
        end
      end
    end else if (commit) begin
      for (int r = 0; r < FIL_S; r++) begin
        for (int c = 0; c < FIL_S; c++) begin
          fil_q[r][c] <= fil_stg[r][c];
        end
      end
      for (int r = 0; r < DI_H; r++) begin
        for (int c = 0; c < DI_W; c++) begin
          dat_q[r][c] <= dat_stg[r][c];
        end
      end
      dat_q[DI_H-1][DI_W-1] <= in_data;
    end
  end

  assign FILTER    = fil_q;
  assign DATA_IN   = dat_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_conv_in_loader.sv
module tb_conv_in_loader;

  localparam int NF = 9;
  localparam int ND = 49;
`ifdef CONV_FILTER_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  logic signed [15:0] in_data;
  logic in_ready, out_valid, frame_err;
  logic signed [15:0] FILTER  [0:2][0:2];
  logic signed [15:0] DATA_IN [0:6][0:6];
`ifdef CONV_FILTER_REUSE_EN
  logic keep_filter;
`endif

  conv_in_loader dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CONV_FILTER_REUSE_EN
    .keep_filter(keep_filter),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .FILTER     (FILTER),
    .DATA_IN    (DATA_IN),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame words collected in a queue; a frame is complete
  // when it holds the expected number of words and the last one has in_last.
  bit m_idle, m_ld, m_hold, m_err, kf;
  int m_nfil;
  logic signed [15:0] q[$];
  logic signed [15:0] exp_fil [0:2][0:2];
  logic signed [15:0] exp_dat [0:6][0:6];
  logic signed [15:0] fq[$];
  int ncyc, first_ov;

  task automatic model_commit();
    for (int i = 0; i < m_nfil; i++) exp_fil[i / 3][i % 3] = q[i];
    for (int i = 0; i < ND; i++) exp_dat[i / 7][i % 7] = q[m_nfil + i];
    q.delete();
    m_hold = 1'b1;
    m_ld   = 1'b0;
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit after it.
  task automatic cyc(input bit v, input logic signed [15:0] d, input bit l,
                     input bit ordy, output bit acc);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
`ifdef CONV_FILTER_REUSE_EN
    keep_filter = kf;
`endif
    acc = v && m_ld;
    @(posedge clk);
    #1;
    ncyc++;
    m_err = 1'b0;
    if (m_idle) begin
      m_idle = 1'b0;
      m_ld   = 1'b1;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        m_ld   = 1'b1;
        m_nfil = (REUSE && kf) ? 0 : NF;
        q.delete();
      end
    end else if (acc) begin
      q.push_back(d);
      if (l && q.size() == m_nfil + ND) begin
        model_commit();
      end else if (l || q.size() == m_nfil + ND) begin
        m_err  = 1'b1;
        m_nfil = NF;
        q.delete();
      end
    end
    chk("in_ready", 32'(in_ready), 32'(m_ld));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    if (out_valid && first_ov == 0) first_ov = ncyc + 1;
    @(negedge clk);
  endtask

  task automatic check_arrays(input string tag);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("%s_FILTER[%0d][%0d]", tag, r, c), 32'(FILTER[r][c]), 32'(exp_fil[r][c]));
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        chk($sformatf("%s_DATA_IN[%0d][%0d]", tag, r, c), 32'(DATA_IN[r][c]), 32'(exp_dat[r][c]));
  endtask

  // vmode: 0 = valid always, 1 = valid on even-numbered cycles, 2 = random
  task automatic send(input int n, input int lastpos, input int vmode);
    int idx = 0;
    int guard = 0;
    bit acc, v;
    while (idx < n && guard < 2000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = ((ncyc + 1) % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cyc(v, v ? fq[idx] : 16'($urandom), (idx == lastpos), 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    chk("send_words", 32'(idx), 32'(n));
  endtask

  task automatic release_tile();
    bit acc;
    cyc(1'b0, 16'sd0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) exp_fil[r][c] = '0;
    for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) exp_dat[r][c] = '0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    check_arrays("rst");
    m_idle = 1'b1; m_ld = 1'b0; m_hold = 1'b0; m_err = 1'b0;
    m_nfil = NF;
    q.delete();
    ncyc = 0;
    first_ov = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill_seq();
    fq.delete();
    for (int i = 0; i < NF + ND; i++) fq.push_back(16'(i + 1));
  endtask

  task automatic fill_rand(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0; kf = 1'b0;
`ifdef CONV_FILTER_REUSE_EN
    keep_filter = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Sequential frame, continuous valid
    fill_seq();
    send(NF + ND, NF + ND - 1, 0);
    chk("lat_cont", 32'(first_ov), 32'd60);
    chk("fil22", 32'(FILTER[2][2]), 32'd9);
    chk("dat66", 32'(DATA_IN[6][6]), 32'd58);
    check_arrays("seq");

    // Back-pressure in HOLD with a word waiting
    fill_rand(NF + ND);
    for (int i = 0; i < 20; i++) cyc(1'b1, fq[0], 1'b0, 1'b0, acc);
    check_arrays("hold");
    cyc(1'b1, fq[0], 1'b0, 1'b1, acc);
    send(NF + ND, NF + ND - 1, 2);
    check_arrays("rand");
    release_tile();

    // Toggled valid after reset
    do_reset();
    fill_seq();
    send(NF + ND, NF + ND - 1, 1);
    chk("lat_toggle", 32'(first_ov), 32'd117);
    check_arrays("toggle");
    release_tile();

    // Early in_last on word 30
    fill_rand(30);
    send(30, 29, 2);
    release_tile();
    check_arrays("err_early");
    // Missing in_last on final word
    fill_rand(NF + ND);
    send(NF + ND, -1, 0);
    release_tile();
    check_arrays("err_nolast");
    fill_rand(NF + ND);
    send(NF + ND, NF + ND - 1, 2);
    check_arrays("after_err");
    release_tile();

    // Reset at word 40
    fill_rand(NF + ND);
    idx = 0;
    while (idx < 40 && ncyc < 4000) begin
      cyc(1'b1, fq[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("pre_rst_words", 32'(idx), 32'd40);
    do_reset();
    fill_rand(NF + ND);
    send(NF + ND, NF + ND - 1, 2);
    check_arrays("after_rst");

    if (REUSE) begin
      kf = 1'b1;
      release_tile();
      kf = 1'b0;
      fill_rand(ND);
      send(ND, ND - 1, 0);
      check_arrays("reuse");
    end
    release_tile();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_in_loader.md
CONV_IN_LOADER -- requirements
Module: conv_in_loader

Interface
REQ-001 Parameter INWIDTH, default 16, word width in bits, signed Q3.12.
REQ-002 Parameter DI_W, default 7, ifmap columns.
REQ-003 Parameter DI_H, default 7, ifmap rows.
REQ-004 Parameter FIL_S, default 3, square filter side.
REQ-005 Port clk, input, 1, single clock; all state on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1, DRAM-side word valid.
REQ-008 Port in_ready, output, 1, loader accepts word.
REQ-009 Port in_data, input, INWIDTH, signed word, row-major.
REQ-010 Port in_last, input, 1, marks final word of a tile frame.
REQ-011 Port out_valid, output, 1, complete tile presented to PE array.
REQ-012 Port out_ready, input, 1, PE array consumes tile.
REQ-013 Port FILTER, output, signed INWIDTH [0:FIL_S-1][0:FIL_S-1], filter weights.
REQ-014 Port DATA_IN, output, signed INWIDTH [0:DI_H-1][0:DI_W-1], ifmap tile.
REQ-015 Port frame_err, output, 1, one-cycle pulse on framing error.

Function
REQ-016 States: IDLE, LOAD_FIL, LOAD_DAT, HOLD, encoded as a package enum.
REQ-017 IDLE -> LOAD_FIL unconditionally on the first clock after reset release.
REQ-018 in_ready SHALL be 1 exactly in LOAD_FIL and LOAD_DAT, 0 in IDLE and HOLD.
REQ-019 Transfer occurs on a cycle with in_valid && in_ready; no other cycle alters buffers or counters.
REQ-020 Frame order: FIL_S*FIL_S filter words then DI_H*DI_W ifmap words, each row-major; col counter wraps 0..W-1 and increments row on wrap.
REQ-021 LOAD_FIL: word stored to FILTER[row][col]; after word FIL_S*FIL_S-1 counters clear and state -> LOAD_DAT.
REQ-022 LOAD_DAT: word stored to DATA_IN[row][col]; after word DI_H*DI_W-1 state -> HOLD.
REQ-023 out_valid SHALL be registered: 1 in HOLD only, first asserted the cycle after the last word is accepted.
REQ-024 HOLD: FILTER and DATA_IN are stable; on out_valid && out_ready, counters clear and state -> LOAD_FIL next cycle.
REQ-025 in_last asserted on the final ifmap word is legal; in_last on any other accepted word, or absent on the final word, SHALL pulse frame_err for one cycle, discard the partial frame, clear counters and go to LOAD_FIL.
REQ-026 On frame error, buffers keep old contents; out_valid stays 0.
REQ-027 Words are stored verbatim; no arithmetic, sign extension or saturation.
REQ-028 Throughput: one word per cycle while in_valid stays high; tile latency = FIL_S*FIL_S + DI_H*DI_W cycles + 1.

Reset
REQ-029 rst low SHALL asynchronously force: state IDLE, counters 0, in_ready 0, out_valid 0, frame_err 0, all FILTER and DATA_IN elements 0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the tile entirely; no partial tile is ever presented.

Configuration
REQ-031 Macro CONV_FILTER_REUSE_EN: when defined, input port keep_filter (1 bit) is added; if keep_filter is 1 at the out_ready handshake, next state is LOAD_DAT, the frame omits filter words and FILTER is retained.
REQ-032 Without CONV_FILTER_REUSE_EN the port is absent and every frame carries filter words.

Structure
REQ-033 Package conv_pkg SHALL hold INWIDTH, DI_W, DI_H, FIL_S, DO_W, DO_H defaults and the loader state enum.
REQ-034 One sub-module conv_ld_cnt (row/col counter with parameterised width/height, clear, enable, wrap flag) SHALL be instantiated once.

Verification
REQ-035 Stream filter 1..9 then ifmap 10..58, in_valid constant, in_last on word 58 -> out_valid at cycle 60, FILTER[2][2]=9, DATA_IN[6][6]=58.
REQ-036 Hold out_ready 0 for 20 cycles in HOLD with in_valid 1 -> in_ready 0, arrays unchanged, no words lost; out_ready 1 -> LOAD_FIL next cycle.
REQ-037 in_valid toggled 1/0 every cycle -> same arrays as REQ-035, out_valid after 117 cycles.
REQ-038 in_last on word 30 -> frame_err pulse one cycle, out_valid 0; the next clean frame loads correctly.
REQ-039 rst low at word 40 -> all outputs 0 immediately; a full new frame after release yields a correct tile.
REQ-040 With CONV_FILTER_REUSE_EN, keep_filter 1 at handshake, next frame of 49 words -> FILTER unchanged, DATA_IN updated.
